// File: rtl/locked_reg_bank_arbiter.sv
// Round-robin shared access to a bank of 16-bit registers, each with a sticky
// write lock. dbg_state reports the access FSM: 0=IDLE, 1=EXEC, 2=RESP.
module locked_reg_bank_arbiter #(
  parameter int NREQ  = 2,
  parameter int NREGS = 4,
  parameter int AW    = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  Clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*16-1:0]    req_data,
  input  logic [NREQ-1:0]       req_lock,
  input  logic                  scan_mode,
  input  logic                  debug_unlocked,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  err,
  output logic [IDW-1:0]        resp_id,
  output logic [NREGS*16-1:0]   reg_q,
  output logic [NREGS-1:0]      lock_status,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester holds req with addr/data/lock stable until it sees
  // its one-cycle gnt pulse, and drops req in that gnt cycle. Inputs are only
  // sampled on an IDLE edge; the answer arrives as a one-cycle done pulse with
  // err and resp_id valid alongside it.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  cur_id;
  logic [AW-1:0]   cur_addr;
  logic [15:0]     cur_data;
  logic            cur_lock;
  logic [15:0]     regs [NREGS];

  // Permission never depends on these two inputs.
  logic unused_test_inputs;
  assign unused_test_inputs = ^{scan_mode, debug_unlocked};

  assign dbg_state = state;

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_q[i*16 +: 16] = regs[i];
    end
  end

  // First requester at or after rr_ptr, searching upward with wrap.
  logic           any_req;
  logic [IDW-1:0] win;

  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_req && req[IDW'(idx)]) begin
        any_req = 1'b1;
        win     = IDW'(idx);
      end
    end
  end

  // Address decode of the latched access; out-of-range addresses match nothing.
  logic addr_ok;
  logic addr_locked;

  always_comb begin
    addr_ok     = 1'b0;
    addr_locked = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (cur_addr == AW'(i)) begin
        addr_ok     = 1'b1;
        addr_locked = lock_status[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      cur_addr    <= '0;
      cur_data    <= '0;
      cur_lock    <= 1'b0;
      gnt         <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      resp_id     <= '0;
      lock_status <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cur_id   <= win;
            cur_addr <= req_addr[int'(win)*AW +: AW];
            cur_data <= req_data[int'(win)*16 +: 16];
            cur_lock <= req_lock[win];
            if (int'(win) == NREQ - 1) rr_ptr <= '0;
            else                       rr_ptr <= win + 1'b1;
            gnt   <= NREQ'(1) << win;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (addr_ok && !addr_locked) begin
            for (int i = 0; i < NREGS; i++) begin
              if (cur_addr == AW'(i)) begin
                regs[i] <= cur_data;
                if (cur_lock) lock_status[i] <= 1'b1;
              end
            end
          end
          err     <= !(addr_ok && !addr_locked);
          done    <= 1'b1;
          resp_id <= cur_id;
          state   <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/locked_reg_bank_arbiter.md
Name: locked_reg_bank_arbiter

Overview:
- Shares a bank of lockable 16-bit configuration registers between NREQ requesters (e.g. CPU, DMA, debug port).
- Round-robin arbitration; one access in flight at a time.
- Each register carries a sticky lock bit, set only by a locked write and cleared only by reset.
- Write permission depends solely on the lock bit. scan_mode and debug_unlocked never bypass a lock; they are ports only so the bypass-free property can be verified.

Parameters:
- NREQ, 2, number of requesters (2..8).
- NREGS, 4, number of 16-bit registers in the bank.
- AW, 2, address width, with 2**AW >= NREGS.

Ports:
- Clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_data  in  NREQ*16  packed write data.
- req_lock  in  NREQ  set the target lock bit after the write.
- scan_mode  in  1  test mode; no effect on permission.
- debug_unlocked  in  1  debug state; no effect on permission.
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- done  out  1  completion pulse, 1 cycle.
- err  out  1  valid with done: access rejected.
- resp_id  out  $clog2(NREQ) (min 1)  index of the requester being answered.
- reg_q  out  NREGS*16  packed register contents.
- lock_status  out  NREGS  per-register lock bits.

Behaviour:
- Reset (async, resetn=0): state=IDLE; reg_q=0; lock_status=0; gnt=0; done=0; err=0; resp_id=0; rr_ptr=0. Assertion mid-access aborts it: no write, no done.
- FSM is IDLE -> EXEC -> RESP -> IDLE. Throughput is at most one access per 3 cycles.
- IDLE:
  - If any req bit is set at edge t, choose the first set bit at or after rr_ptr, searching upward with wrap.
  - Latch the winner's id, addr, data and lock.
  - Update rr_ptr = (winner+1) mod NREQ.
  - Go to EXEC. gnt[winner]=1 during cycle t+1 only.
  - If no req is set, stay in IDLE.
- EXEC (edge t+1):
  - If addr >= NREGS: err=1, no change.
  - Else if lock_status[addr]=1: err=1, no change, regardless of scan_mode or debug_unlocked.
  - Else: reg_q[addr] <= data; if lock=1 then lock_status[addr] <= 1 on the same edge. err=0.
  - Go to RESP.
- RESP (cycle t+2):
  - done=1; err as computed; resp_id = latched id.
  - reg_q and lock_status already show the update.
  - Next edge returns to IDLE.
- Requester protocol:
  - Hold req, addr, data and lock stable until gnt is seen; drop req in the gnt cycle.
  - req still high when the FSM returns to IDLE counts as a new request.
  - Inputs are sampled only at the IDLE edge. Changes during EXEC or RESP are ignored.
- Locks:
  - A write with lock=1 to an unlocked register writes the data and then locks.
  - Any write to a locked register, with or without lock=1, errors and changes nothing.
  - There is no unlock path except resetn.
- Invariants:
  - gnt is one-hot or zero.
  - done and gnt are never high in the same cycle.
  - err=0 whenever done=0.
- Out-of-range addresses (NREGS < 2**AW) have no side effects.

Test Plan:
- Reset then a single write: req[0]=1, addr=2, data=16'hA5A5, lock=0.
  - gnt=2'b01 at t+1.
  - done=1, err=0, resp_id=0, reg_q[2]=A5A5 at t+2.
  - lock_status=4'b0000.
- Lock then retry: requester 1 writes addr 1, data 16'h1234, lock=1. Then requester 0 writes addr 1, data 16'hFFFF.
  - First access: lock_status[1]=1, reg_q[1]=1234.
  - Second access: done with err=1, reg_q[1] stays 1234.
- Bypass check: with addr 1 locked, set scan_mode=1 and debug_unlocked=1, then write 16'h0000.
  - err=1; reg_q[1] unchanged; lock_status[1] stays 1.
- Contention: req=2'b11 held continuously, each requester re-asserting after its gnt.
  - gnt sequence is 01, 10, 01, 10, one grant per 3 cycles.
  - resp_id alternates 0,1,0,1.
- Out-of-range address: NREGS=3, write addr 3.
  - err=1; reg_q and lock_status unchanged.
- Reset mid-operation: assert resetn=0 during EXEC of a write to addr 0.
  - All outputs return to 0 immediately; done is never pulsed.
  - After release, addr 0 is unlocked and writable.
